// File: rtl/nic_audit_pkg.sv
// Shared types, register offsets and helpers for the multi-channel NIC bus audit hook.
package nic_audit_pkg;

    typedef struct packed {
        logic unauth;
        logic suspicious;
    } cause_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  ch;
        cause_t      cause;
        logic [1:0]  rsvd;
        logic [23:0] ts;
    } log_entry_t;

    localparam logic [7:0] OFF_LOG_POP    = 8'h00;
    localparam logic [7:0] OFF_LOG_STATUS = 8'h04;
    localparam logic [7:0] OFF_CFG_INFO   = 8'h08;
    localparam logic [7:0] OFF_CNT_BASE   = 8'h10;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] DEADBEEF_WORD = 32'hDEADBEEF;

    localparam int POP_MAX_W = 256;

    // Counts set bits in the low 'width' bits; callers zero-extend into POP_MAX_W.
    function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] vec, input int width);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (i < width) n = n + 9'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/nic_audit_ch_detect.sv
// Per-channel detector: toggle-burst tracking against the last valid word plus tag window check.
module nic_audit_ch_detect
    import nic_audit_pkg::*;
#(
    parameter int          DATA_W           = 32,
    parameter int          TOGGLE_THRESHOLD = 12,
    parameter int          BURST_LIMIT      = 4,
    parameter logic [15:0] ALLOWED_ADDR_MIN = 16'h1000,
    parameter logic [15:0] ALLOWED_ADDR_MAX = 16'h10FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_valid,
    input  logic [DATA_W-1:0] data,
    output cause_t            cause
);

    localparam int HD_W = $clog2(DATA_W + 1);
    localparam int BC_W = $clog2(BURST_LIMIT + 1);

    logic [DATA_W-1:0] last_reg;
    logic [BC_W-1:0]   burst_reg;
    logic [BC_W-1:0]   burst_next;
    logic [HD_W-1:0]   hd;
    logic [15:0]       tag;
    logic              toggle;
    logic              suspicious;
    logic              unauth;

    always_comb begin
        hd         = HD_W'(popcount(POP_MAX_W'(data ^ last_reg), DATA_W));
        tag        = data[DATA_W-1 -: 16];
        toggle     = (hd >= HD_W'(TOGGLE_THRESHOLD));
        // Uses the burst length before this beat, so the BURST_LIMIT-th toggle beat is the first flagged.
        suspicious = toggle && (burst_reg >= BC_W'(BURST_LIMIT - 1));
        unauth     = (tag < ALLOWED_ADDR_MIN) || (tag > ALLOWED_ADDR_MAX);
        if (!toggle)
            burst_next = '0;
        else if (burst_reg == BC_W'(BURST_LIMIT))
            burst_next = burst_reg;
        else
            burst_next = burst_reg + BC_W'(1);
        cause = '0;
        if (bus_valid) begin
            cause.unauth     = unauth;
            cause.suspicious = suspicious;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg  <= '0;
            burst_reg <= '0;
        end else if (bus_valid) begin
            last_reg  <= data;
            burst_reg <= burst_next;
        end
    end

endmodule

// File: rtl/nic_bus_audit_hook_mc.sv
// Multi-channel NIC bus audit hook: per-channel detectors, pending slots, round-robin
// drain into a timestamped event log, and a read-only AXI-lite register window.
module nic_bus_audit_hook_mc
    import nic_audit_pkg::*;
#(
    parameter int          NUM_CH           = 4,
    parameter int          DATA_W           = 32,
    parameter int          TOGGLE_THRESHOLD = 12,
    parameter int          BURST_LIMIT      = 4,
    parameter logic [15:0] ALLOWED_ADDR_MIN = 16'h1000,
    parameter logic [15:0] ALLOWED_ADDR_MAX = 16'h10FF,
    parameter int          FIFO_DEPTH       = 16,
    parameter int          TS_W             = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        bus_valid,
    input  logic [NUM_CH*DATA_W-1:0] data_bus,
    input  logic [31:0]              s_axil_araddr,
    input  logic                     s_axil_arvalid,
    input  logic                     s_axil_rready,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    output logic                     irq,
    output logic                     log_overflow
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    cause_t            ch_cause [NUM_CH];
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] drain;
    logic [NUM_CH-1:0] drop;

    logic [NUM_CH-1:0] slot_valid_reg;
    cause_t            slot_cause_reg [NUM_CH];
    logic [23:0]       slot_ts_reg    [NUM_CH];
    logic [63:0]       cnt_reg        [NUM_CH];

    logic [TS_W-1:0]   ts_reg;
    logic [23:0]       ts24;

    logic [CH_W-1:0]   rr_ptr_reg;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W:0]     rr_cand;
    logic              grant_any;

    log_entry_t        fifo_mem [FIFO_DEPTH];
    log_entry_t        push_entry;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]  fifo_count_reg;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;

    logic [15:0]       drop_cnt_reg;
    logic [3:0]        drop_sum;
    logic [16:0]       drop_total;
    logic              overflow_reg;
    logic              irq_reg;

    logic              arready_reg;
    logic              rvalid_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;
    logic              ar_accept;
    logic [5:0]        addr_idx;
    logic [5:0]        cnt_off;
    logic [31:0]       reg_rdata;
    logic [1:0]        reg_rresp;
    logic              unused_araddr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            nic_audit_ch_detect #(
                .DATA_W           (DATA_W),
                .TOGGLE_THRESHOLD (TOGGLE_THRESHOLD),
                .BURST_LIMIT      (BURST_LIMIT),
                .ALLOWED_ADDR_MIN (ALLOWED_ADDR_MIN),
                .ALLOWED_ADDR_MAX (ALLOWED_ADDR_MAX)
            ) u_det (
                .clk       (clk),
                .reset     (reset),
                .bus_valid (bus_valid[gi]),
                .data      (data_bus[gi*DATA_W +: DATA_W]),
                .cause     (ch_cause[gi])
            );
            assign ev[gi]    = (ch_cause[gi] != '0);
            assign drain[gi] = fifo_push && (grant_ch == CH_W'(gi));
            assign drop[gi]  = ev[gi] && slot_valid_reg[gi] && !drain[gi];
        end

        if (TS_W >= 24) begin : g_ts_trunc
            assign ts24 = ts_reg[23:0];
        end else begin : g_ts_ext
            assign ts24 = {{(24 - TS_W){1'b0}}, ts_reg};
        end
    endgenerate

    assign addr_idx      = s_axil_araddr[7:2];
    assign unused_araddr = ^{s_axil_araddr[31:8], s_axil_araddr[1:0]};
    assign ar_accept     = s_axil_arvalid && arready_reg;
    assign fifo_full     = (fifo_count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_pop      = ar_accept && (addr_idx == OFF_LOG_POP[7:2]) && (fifo_count_reg != '0);
    // A pop in the same cycle frees the head, so a full log can still take a new entry.
    assign fifo_push     = grant_any && (!fifo_full || fifo_pop);

    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        rr_cand   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_cand = {1'b0, rr_ptr_reg} + (CH_W+1)'(i);
            if (rr_cand >= (CH_W+1)'(NUM_CH)) rr_cand = rr_cand - (CH_W+1)'(NUM_CH);
            if (!grant_any && slot_valid_reg[rr_cand[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_ch  = rr_cand[CH_W-1:0];
            end
        end
        push_entry       = '0;
        push_entry.valid = 1'b1;
        push_entry.ch    = 3'(grant_ch);
        push_entry.cause = slot_cause_reg[grant_ch];
        push_entry.ts    = slot_ts_reg[grant_ch];
    end

    always_comb begin
        drop_sum = '0;
        for (int c = 0; c < NUM_CH; c++) drop_sum = drop_sum + 4'(drop[c]);
        drop_total = {1'b0, drop_cnt_reg} + 17'(drop_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) ts_reg <= '0;
        else       ts_reg <= ts_reg + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_reg <= '0;
            rr_ptr_reg     <= '0;
            drop_cnt_reg   <= '0;
            overflow_reg   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                slot_cause_reg[c] <= '0;
                slot_ts_reg[c]    <= '0;
                cnt_reg[c]        <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ev[c] && (!slot_valid_reg[c] || drain[c])) begin
                    slot_valid_reg[c] <= 1'b1;
                    slot_cause_reg[c] <= ch_cause[c];
                    slot_ts_reg[c]    <= ts24;
                end else if (drain[c]) begin
                    slot_valid_reg[c] <= 1'b0;
                end
                if (ev[c]) cnt_reg[c] <= cnt_reg[c] + 64'd1;
            end
            if (fifo_push)
                rr_ptr_reg <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            if (drop != '0) overflow_reg <= 1'b1;
            drop_cnt_reg <= drop_total[16] ? 16'hFFFF : drop_total[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            irq_reg        <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (fifo_push && !fifo_pop)      fifo_count_reg <= fifo_count_reg + CNT_W'(1);
            else if (!fifo_push && fifo_pop) fifo_count_reg <= fifo_count_reg - CNT_W'(1);
            irq_reg <= (fifo_count_reg != '0);
        end
    end

    always_comb begin
        reg_rdata = DEADBEEF_WORD;
        reg_rresp = RESP_SLVERR;
        cnt_off   = addr_idx - OFF_CNT_BASE[7:2];
        if (addr_idx == OFF_LOG_POP[7:2]) begin
            reg_rdata = '0;
            reg_rresp = RESP_OKAY;
        end else if (addr_idx == OFF_LOG_STATUS[7:2]) begin
            reg_rdata = {drop_cnt_reg, 16'(fifo_count_reg)};
            reg_rresp = RESP_OKAY;
        end else if (addr_idx == OFF_CFG_INFO[7:2]) begin
            reg_rdata = {8'h00, 8'(DATA_W), 8'(FIFO_DEPTH - 1), 4'h0, 4'(NUM_CH)};
            reg_rresp = RESP_OKAY;
        end else if (addr_idx >= OFF_CNT_BASE[7:2]) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_off[5:1] == 5'(c)) begin
                    reg_rdata = cnt_off[0] ? cnt_reg[c][63:32] : cnt_reg[c][31:0];
                    reg_rresp = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else if (ar_accept) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rresp_reg   <= reg_rresp;
            if (addr_idx == OFF_LOG_POP[7:2])
                rdata_reg <= (fifo_count_reg != '0) ? 32'(fifo_mem[rd_ptr_reg]) : 32'h0;
            else
                rdata_reg <= reg_rdata;
        end else if (rvalid_reg && s_axil_rready) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
        end else if (!rvalid_reg) begin
            arready_reg <= 1'b1;
        end
    end

    assign s_axil_arready = arready_reg;
    assign s_axil_rvalid  = rvalid_reg;
    assign s_axil_rdata   = rdata_reg;
    assign s_axil_rresp   = rresp_reg;
    assign irq            = irq_reg;
    assign log_overflow   = overflow_reg;

endmodule

// File: tb/tb_nic_bus_audit_hook_mc.sv
// Directed bench for nic_bus_audit_hook_mc: scoreboard queues for log entries and read data.
module tb_nic_bus_audit_hook_mc;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   bus_valid;
    logic [127:0] data_bus;
    logic [31:0]  s_axil_araddr;
    logic         s_axil_arvalid;
    logic         s_axil_rready;
    logic         s_axil_arready;
    logic [31:0]  s_axil_rdata;
    logic [1:0]   s_axil_rresp;
    logic         s_axil_rvalid;
    logic         irq;
    logic         log_overflow;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] log_q[$];
    rd_exp_t     rd_q[$];
    logic [23:0] tb_ts;
    logic [23:0] t0;

    nic_bus_audit_hook_mc dut (
        .clk            (clk),
        .reset          (reset),
        .bus_valid      (bus_valid),
        .data_bus       (data_bus),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .irq            (irq),
        .log_overflow   (log_overflow)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: value seen at a negedge is the stamp taken at the next rising edge.
    always @(posedge clk) tb_ts <= reset ? 24'd0 : tb_ts + 24'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] entry(input int ch, input logic [1:0] cause, input logic [23:0] ts);
        return {1'b1, 3'(ch), cause, 2'b00, ts};
    endfunction

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold, input string tag);
        rd_exp_t e;
        int n;
        rd_q.push_back('{exp_data, exp_resp});
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ar_timeout"}, 64'(n >= 50), 64'd0);
        @(posedge clk);
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        n = 0;
        while (!s_axil_rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_r_timeout"}, 64'(n >= 50), 64'd0);
        e = rd_q.pop_front();
        $display("read %-16s addr=%h data=%h resp=%0d exp_data=%h", tag, addr, s_axil_rdata, s_axil_rresp, e.data);
        check({tag, "_data"}, 64'(s_axil_rdata), 64'(e.data));
        check({tag, "_resp"}, 64'(s_axil_rresp), 64'(e.resp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_rvalid"}, 64'(s_axil_rvalid), 64'd1);
            check({tag, "_hold_data"}, 64'(s_axil_rdata), 64'(e.data));
        end
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
        check({tag, "_rvalid_drop"}, 64'(s_axil_rvalid), 64'd0);
        check({tag, "_arready_back"}, 64'(s_axil_arready), 64'd1);
    endtask

    task automatic pop_read(input string tag);
        logic [31:0] exp;
        exp = (log_q.size() != 0) ? log_q.pop_front() : 32'h0;
        axi_read(32'h00, exp, 2'b00, 0, tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arready"}, 64'(s_axil_arready), 64'd0);
        check({tag, "_rvalid"}, 64'(s_axil_rvalid), 64'd0);
        check({tag, "_rdata"}, 64'(s_axil_rdata), 64'd0);
        check({tag, "_rresp"}, 64'(s_axil_rresp), 64'd0);
        check({tag, "_irq"}, 64'(irq), 64'd0);
        check({tag, "_overflow"}, 64'(log_overflow), 64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus_valid      = '0;
        data_bus       = '0;
        s_axil_araddr  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("arready_after_reset", 64'(s_axil_arready), 64'd1);

        // Channel 0: legal tag, small toggles, no events
        for (int i = 0; i < 10; i++) begin
            bus_valid      = 4'b0001;
            data_bus[31:0] = 32'h1050_0000 | 32'(i);
            @(negedge clk);
        end
        bus_valid = '0;
        repeat (3) @(negedge clk);
        check("irq_ch0_quiet", 64'(irq), 64'd0);
        axi_read(32'h04, 32'h0, 2'b00, 0, "status_ch0");
        axi_read(32'h10, 32'h0, 2'b00, 0, "cnt0_lo");

        // Channel 1: single out-of-window tag, check irq latency
        bus_valid       = 4'b0010;
        data_bus[63:32] = 32'h0FFF_0000;
        log_q.push_back(entry(1, 2'b10, tb_ts));
        @(negedge clk);
        bus_valid = '0;
        check("irq_lat_slot", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_lat_fifo", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_rise", 64'(irq), 64'd1);
        axi_read(32'h18, 32'd1, 2'b00, 0, "cnt1_lo");
        axi_read(32'h1C, 32'd0, 2'b00, 0, "cnt1_hi");
        pop_read("pop_ch1");
        check("irq_fall", 64'(irq), 64'd0);
        pop_read("pop_ch1_empty");

        // Channel 2: alternating toggle burst, beats 4..8 suspicious
        for (int i = 0; i < 8; i++) begin
            bus_valid       = 4'b0100;
            data_bus[95:64] = (i % 2 == 0) ? 32'h1000_FFFF : 32'h1000_0000;
            if (i >= 3) log_q.push_back(entry(2, 2'b01, tb_ts));
            @(negedge clk);
        end
        bus_valid = '0;
        repeat (3) @(negedge clk);
        axi_read(32'h20, 32'd5, 2'b00, 0, "cnt2_lo");
        axi_read(32'h04, 32'h0000_0005, 2'b00, 0, "status_ch2");
        check("overflow_clear", 64'(log_overflow), 64'd0);
        for (int i = 0; i < 5; i++) pop_read($sformatf("pop_ch2_%0d", i));
        axi_read(32'h04, 32'h0, 2'b00, 0, "status_drained");

        axi_read(32'h08, 32'h0020_0F04, 2'b00, 3, "cfg_info");
        axi_read(32'h0C, 32'hDEAD_BEEF, 2'b10, 0, "hole_0c");
        axi_read(32'h30, 32'hDEAD_BEEF, 2'b10, 0, "beyond_cnt");
        axi_read(32'h2C, 32'h0, 2'b00, 0, "cnt3_hi");

        // Flood: all channels illegal tag for 40 cycles with no reads
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        t0 = tb_ts;
        for (int k = 0; k < 20; k++)
            log_q.push_back(entry(k % 4, 2'b10, (k < 4) ? t0 : t0 + 24'(k - 3)));
        for (int i = 0; i < 40; i++) begin
            bus_valid = 4'hF;
            data_bus  = {4{32'h2000_0000}};
            @(negedge clk);
        end
        bus_valid = '0;
        data_bus  = '0;
        repeat (3) @(negedge clk);
        check("flood_overflow", 64'(log_overflow), 64'd1);
        axi_read(32'h04, {16'd140, 16'd16}, 2'b00, 0, "status_flood");
        for (int c = 0; c < 4; c++)
            axi_read(32'h10 + 32'(8 * c), 32'd40, 2'b00, 0, $sformatf("flood_cnt%0d", c));
        axi_read(32'h2C, 32'd0, 2'b00, 0, "flood_cnt3_hi");
        for (int k = 0; k < 20; k++) pop_read($sformatf("pop_flood_%0d", k));
        axi_read(32'h04, {16'd140, 16'd0}, 2'b00, 0, "status_flood_done");
        pop_read("pop_flood_empty");

        // Reset while a read response is pending
        s_axil_araddr  = 32'h10;
        s_axil_arvalid = 1'b1;
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        check("pend_rvalid", 64'(s_axil_rvalid), 64'd1);
        check("pend_rdata", 64'(s_axil_rdata), 64'd40);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        check("arready_after_mid_reset", 64'(s_axil_arready), 64'd1);
        axi_read(32'h10, 32'd0, 2'b00, 0, "post_reset_cnt0");
        axi_read(32'h04, 32'd0, 2'b00, 0, "post_reset_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
